mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single-port, byte-wide synchronous RAM (17-bit address, 8-bit data, r_nw control) between the instruction-fetch unit (read-only) and the load/store unit (read/write).
- Serialises each 1/2/4-byte access into per-byte RAM cycles and assembles little-endian 32-bit results.
- Returns each result to the granted requester with a one-cycle done pulse.
- Sits between the CPU front/back ends and the RAM instance on the FPGA top level.

Parameters:
- ADDR_W, 17, RAM byte-address width; all address arithmetic is modulo 2^ADDR_W.

Ports:
- clk  in  1  system clock
- rst  in  1  reset (see Behaviour)
- if_req  in  1  fetch request; held high until if_done
- if_addr  in  ADDR_W  fetch byte address; always a 4-byte access
- if_rdata  out  32  fetched word, valid while if_done=1
- if_done  out  1  one-cycle completion pulse
- ls_req  in  1  load/store request; held high until ls_done
- ls_we  in  1  1=store, 0=load
- ls_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- ls_addr  in  ADDR_W  byte address
- ls_wdata  in  32  store data; byte k is bits [8k+7:8k]
- ls_rdata  out  32  load data, zero-extended, valid while ls_done=1
- ls_done  out  1  one-cycle completion pulse
- ram_en  out  1  RAM enable; constant 1
- ram_r_nw  out  1  1=read, 0=write
- ram_a  out  ADDR_W  RAM byte address
- ram_dout  out  8  write data to RAM d_in
- ram_din  in  8  RAM d_out; valid the cycle after its address is presented

Behaviour:
- Reset: clk and rst are already decided as follows: reset rst, synchronous, active-high; clock clk.
- Reset values: state=IDLE, if_done=0, ls_done=0, if_rdata=0, ls_rdata=0, ram_r_nw=1, ram_a=0, ram_dout=0.
- States: IDLE, RD, WR, DONE.
- Inputs are sampled only in IDLE. Requesters hold addr/size/wdata stable while req=1.
- IDLE (cycle T): on a request, latch source, base, N (1/2/4), we and wdata; clear cnt.
  - Go to WR if the grant is an LSU store, otherwise RD.
  - Grant rule: fixed priority, LSU over IF.
  - With no request, remain in IDLE; ram_r_nw=1, ram_a holds.
- RD (N+1 cycles, cnt=0..N):
  - For cnt<N: ram_a=base+cnt, ram_r_nw=1.
  - For cnt>=1: capture ram_din into result byte cnt-1.
  - At cnt==N: register the result into the source's rdata (upper unused bytes 0) and go to DONE.
- WR (N cycles, cnt=0..N-1):
  - ram_a=base+cnt, ram_r_nw=0, ram_dout=wdata byte cnt.
  - At cnt==N-1: go to DONE.
- DONE (1 cycle):
  - The granted source's done=1, ram_r_nw=1; no grant is made this cycle.
  - Next state is IDLE. A requester may keep req high during DONE without a re-grant.
- Latency, req sampled at T: read done at T+N+2 (word fetch: T+6); write done at T+N+1.
- Wrap-around: base+cnt wraps from 2^ADDR_W-1 to 0.
- Simultaneous if_req and ls_req: grant per arbitration rule; the loser waits, with no lost request.
- rdata holds its last value after done drops.
- Reset mid-operation: abort the access immediately.
  - ram_r_nw=1 from the next cycle; no further bytes are written and no done pulse is issued.
  - Bytes already written remain in RAM.

Optional Feature:
- Macro MEM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - Register last_grant (reset=IF); on a tie, grant the source not granted last.
  - So the first tie after reset goes to LSU, and continuous dual requests alternate.
  - Single requests are granted immediately and update last_grant.
- Undefined: fixed priority, LSU over IF; no last_grant register.

Decomposition:
- Package mem_arb_pkg:
  - state enum (IDLE/RD/WR/DONE)
  - source enum (SRC_IF/SRC_LS)
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - size-to-byte-count function
  - default ADDR_W=17
- Sub-module mem_arb_grant: combinational grant select plus the optional last_grant register. The sequencer stays in mem_arbiter.

Test Plan:
- RAM[0x10..0x13]=11,22,33,44; if_req addr 0x10 at T -> ram_a 0x10,0x11,0x12,0x13 at T+1..T+4; if_done=1 only at T+6; if_rdata=0x44332211.
- Store byte at 0x20, wdata=0xAABBCCDD -> one WR cycle at T+1 (ram_a=0x20, ram_r_nw=0, ram_dout=0xDD); ls_done at T+2. Then load byte at 0x20 -> ls_rdata=0x000000DD.
- if_req and ls_req (half load) both rise at T, macro off -> ls_done at T+4; IF granted at T+5; if_done at T+11.
- Word load at 0x1FFFE -> ram_a sequence 0x1FFFE, 0x1FFFF, 0x00000, 0x00001; result assembled in that byte order.
- Word store at 0x40, rst asserted during the cycle after byte 1 is written -> ram_r_nw=1 next cycle; RAM[0x42..0x43] unchanged; ls_done never asserted; state IDLE.
- MEM_ARB_RR_EN defined, both reqs re-raised after each done -> grants alternate LS, IF, LS, IF.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and helpers for the byte-wide RAM arbiter.
//   state_t    sequencer states (IDLE/RD/WR/DONE)
//   src_t      requester identity (SRC_IF fetch, SRC_LS load/store)
//   SZ_*       ls_size encodings (2'b11 is treated as a word)
//   size_bytes ls_size -> number of byte cycles (1/2/4)
//   DEF_ADDR_W default RAM byte-address width
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 17;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic {
        SRC_IF = 1'b0,
        SRC_LS = 1'b1
    } src_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        case (sz)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// mem_arb_grant: picks which requester wins when the sequencer is idle.
// Build option: MEM_ARB_RR_EN
//   undefined - fixed priority, load/store unit over fetch, purely combinational
//   defined   - round-robin on ties using a last_grant register (reset = fetch)
// Ports:
//   clk, rst     clock / synchronous active-high reset (round-robin build only)
//   grant_en     sequencer is in IDLE and will accept the grant (round-robin only)
//   if_req       fetch request
//   ls_req       load/store request
//   grant_valid  at least one request present
//   grant_ls     1 = load/store wins, 0 = fetch wins
module mem_arb_grant
    import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
    input  logic clk,
    input  logic rst,
    input  logic grant_en,
`endif
    input  logic if_req,
    input  logic ls_req,
    output logic grant_valid,
    output logic grant_ls
);

`ifdef MEM_ARB_RR_EN
    src_t last_grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= SRC_IF;
        end else if (grant_en && grant_valid) begin
            last_grant <= grant_ls ? SRC_LS : SRC_IF;
        end
    end

    always_comb begin
        grant_valid = if_req | ls_req;
        grant_ls    = ls_req;
        // On a tie, hand the RAM to whoever did not have it last.
        if (if_req && ls_req) begin
            grant_ls = (last_grant == SRC_IF);
        end
    end
`else
    always_comb begin
        grant_valid = if_req | ls_req;
        grant_ls    = ls_req;
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide synchronous RAM between the fetch unit
// (read-only, always 4 bytes) and the load/store unit (1/2/4 bytes, read or
// write). Each access is split into per-byte RAM cycles; reads are assembled
// little-endian and returned with a one-cycle done pulse.
// Build option: MEM_ARB_RR_EN selects round-robin tie-breaking (see mem_arb_grant).
// Ports:
//   clk, rst              clock / synchronous active-high reset
//   if_req/if_addr        fetch request and byte address
//   if_rdata/if_done      fetched word and completion pulse
//   ls_req/ls_we/ls_size  load/store request, direction, size
//   ls_addr/ls_wdata      byte address and store data
//   ls_rdata/ls_done      zero-extended load data and completion pulse
//   ram_en/ram_r_nw/ram_a RAM enable (tied 1), read-not-write, byte address
//   ram_dout/ram_din      RAM write data / read data (one cycle after address)
//
// state | meaning
// IDLE  | waiting; sample requests and latch the winning access
// RD    | present N read addresses, capture bytes one cycle later (N+1 cycles)
// WR    | present N write addresses with data bytes (N cycles)
// DONE  | pulse the granted source's done for one cycle, then back to IDLE
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_done,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [1:0]        ls_size,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic [31:0]       ls_rdata,
    output logic              ls_done,
    output logic              ram_en,
    output logic              ram_r_nw,
    output logic [ADDR_W-1:0] ram_a,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din
);

    state_t            state_q, state_d;
    src_t              src_q;
    logic [ADDR_W-1:0] base_q;
    logic [2:0]        n_q;
    logic [2:0]        cnt_q;
    logic [31:0]       wdata_q;
    logic [31:0]       res_q;
    logic [31:0]       assembled;
    logic [31:0]       if_rdata_q, ls_rdata_q;
    logic [ADDR_W-1:0] ram_a_q;
    logic [7:0]        ram_dout_q;
    logic              present;
    logic              grant_valid, grant_ls;

    mem_arb_grant u_grant (
`ifdef MEM_ARB_RR_EN
        .clk         (clk),
        .rst         (rst),
        .grant_en    (state_q == IDLE),
`endif
        .if_req      (if_req),
        .ls_req      (ls_req),
        .grant_valid (grant_valid),
        .grant_ls    (grant_ls)
    );

    assign ram_en   = 1'b1;
    assign if_rdata = if_rdata_q;
    assign ls_rdata = ls_rdata_q;
    assign if_done  = (state_q == DONE) && (src_q == SRC_IF);
    assign ls_done  = (state_q == DONE) && (src_q == SRC_LS);

    // Reset gates the write strobe combinationally so a store caught by reset
    // cannot put one more byte into the RAM on the reset edge.
    assign ram_r_nw = !((state_q == WR) && !rst);

    always_comb begin
        present  = ((state_q == RD) && (cnt_q < n_q)) || (state_q == WR);
        // Address and write data hold their last value when nothing is presented.
        ram_a    = present ? ADDR_W'(base_q + ADDR_W'(cnt_q)) : ram_a_q;
        ram_dout = ram_dout_q;
        if (state_q == WR) begin
            case (cnt_q[1:0])
                2'd0:    ram_dout = wdata_q[7:0];
                2'd1:    ram_dout = wdata_q[15:8];
                2'd2:    ram_dout = wdata_q[23:16];
                default: ram_dout = wdata_q[31:24];
            endcase
        end
    end

    // RAM data lags its address by one cycle, so byte cnt-1 arrives at cnt.
    always_comb begin
        assembled = res_q;
        if (state_q == RD) begin
            case (cnt_q)
                3'd1:    assembled[7:0]   = ram_din;
                3'd2:    assembled[15:8]  = ram_din;
                3'd3:    assembled[23:16] = ram_din;
                3'd4:    assembled[31:24] = ram_din;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    state_d = (grant_ls && ls_we) ? WR : RD;
                end
            end
            RD: begin
                if (cnt_q == n_q) begin
                    state_d = DONE;
                end
            end
            WR: begin
                if (cnt_q == n_q - 3'd1) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            src_q      <= SRC_IF;
            base_q     <= '0;
            n_q        <= 3'd4;
            cnt_q      <= '0;
            wdata_q    <= '0;
            res_q      <= '0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
            ram_a_q    <= '0;
            ram_dout_q <= '0;
        end else begin
            state_q    <= state_d;
            ram_a_q    <= ram_a;
            ram_dout_q <= ram_dout;
            case (state_q)
                IDLE: begin
                    if (grant_valid) begin
                        src_q   <= grant_ls ? SRC_LS : SRC_IF;
                        base_q  <= grant_ls ? ls_addr : if_addr;
                        n_q     <= grant_ls ? size_bytes(ls_size) : 3'd4;
                        wdata_q <= ls_wdata;
                        cnt_q   <= '0;
                        res_q   <= '0;
                    end
                end
                RD: begin
                    res_q <= assembled;
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q == n_q) begin
                        if (src_q == SRC_LS) ls_rdata_q <= assembled;
                        else                 if_rdata_q <= assembled;
                    end
                end
                WR: begin
                    cnt_q <= cnt_q + 3'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed, table-driven bench for mem_arbiter with a
// behavioural byte RAM (read data one cycle after address, write on clock).
// Build option: MEM_ARB_RR_EN changes the expected tie-break sequence.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [16:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        ls_req = 1'b0;
    logic        ls_we = 1'b0;
    logic [1:0]  ls_size = 2'b00;
    logic [16:0] ls_addr = '0;
    logic [31:0] ls_wdata = '0;
    logic [31:0] ls_rdata;
    logic        ls_done;
    logic        ram_en;
    logic        ram_r_nw;
    logic [16:0] ram_a;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din;

    mem_arbiter #(.ADDR_W(17)) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_done  (if_done),
        .ls_req   (ls_req),
        .ls_we    (ls_we),
        .ls_size  (ls_size),
        .ls_addr  (ls_addr),
        .ls_wdata (ls_wdata),
        .ls_rdata (ls_rdata),
        .ls_done  (ls_done),
        .ram_en   (ram_en),
        .ram_r_nw (ram_r_nw),
        .ram_a    (ram_a),
        .ram_dout (ram_dout),
        .ram_din  (ram_din)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:131071];

    always @(posedge clk) begin
        if (ram_en) begin
            ram_din <= mem[ram_a];
            if (!ram_r_nw) mem[ram_a] = ram_dout;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    logic [16:0] tr_a   [4];
    logic        tr_rnw [4];
    logic [7:0]  tr_dout[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One single-source access; lat counts negedges after the sampling edge.
    task automatic access(input logic ls, input logic we, input logic [1:0] sz,
                          input logic [16:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output int lat);
        @(negedge clk);
        if (ls) begin
            ls_req = 1'b1; ls_we = we; ls_size = sz; ls_addr = a; ls_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = a;
        end
        lat = -1;
        rd  = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k <= 4) begin
                tr_a[k-1] = ram_a; tr_rnw[k-1] = ram_r_nw; tr_dout[k-1] = ram_dout;
            end
            if (ls ? ls_done : if_done) begin
                lat = k;
                rd  = ls ? ls_rdata : if_rdata;
                break;
            end
        end
        ls_req = 1'b0;
        if_req = 1'b0;
    endtask

    typedef struct {
        logic        ls;
        logic        we;
        logic [1:0]  sz;
        logic [16:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        int          exp_lat;
    } vec_t;

    vec_t vecs[11];

    initial begin
        logic [31:0] rd;
        int          lat, ls_k, if_k, got, exp_got;
        logic [31:0] if_cap;

        for (int i = 0; i < 131072; i++) mem[i] = 8'h00;
        mem[17'h10] = 8'h11; mem[17'h11] = 8'h22; mem[17'h12] = 8'h33; mem[17'h13] = 8'h44;
        mem[17'h30] = 8'h5A; mem[17'h31] = 8'h6B; mem[17'h32] = 8'h7C; mem[17'h33] = 8'h8D;
        mem[17'h1FFFE] = 8'hA1; mem[17'h1FFFF] = 8'hA2; mem[17'h0] = 8'hA3; mem[17'h1] = 8'hA4;
        for (int i = 17'h40; i < 17'h44; i++) mem[i] = 8'hEE;

        //              ls    we    sz     addr       wdata         exp_rd        lat
        vecs[0]  = '{1'b0, 1'b0, 2'b10, 17'h00010, 32'h0,        32'h44332211, 6};
        vecs[1]  = '{1'b1, 1'b1, 2'b00, 17'h00020, 32'hAABBCCDD, 32'h0,        2};
        vecs[2]  = '{1'b1, 1'b0, 2'b00, 17'h00020, 32'h0,        32'h000000DD, 3};
        vecs[3]  = '{1'b1, 1'b0, 2'b01, 17'h00030, 32'h0,        32'h00006B5A, 4};
        vecs[4]  = '{1'b1, 1'b0, 2'b10, 17'h00030, 32'h0,        32'h8D7C6B5A, 6};
        vecs[5]  = '{1'b1, 1'b0, 2'b11, 17'h00030, 32'h0,        32'h8D7C6B5A, 6};
        vecs[6]  = '{1'b1, 1'b1, 2'b01, 17'h00050, 32'h12345678, 32'h0,        3};
        vecs[7]  = '{1'b1, 1'b0, 2'b10, 17'h00050, 32'h0,        32'h00005678, 6};
        vecs[8]  = '{1'b1, 1'b1, 2'b10, 17'h00060, 32'hCAFEBABE, 32'h0,        5};
        vecs[9]  = '{1'b1, 1'b0, 2'b10, 17'h00060, 32'h0,        32'hCAFEBABE, 6};
        vecs[10] = '{1'b1, 1'b0, 2'b00, 17'h00012, 32'h0,        32'h00000033, 3};

        // reset values
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_if_done",  {31'b0, if_done},  32'h0);
        chk("rst_ls_done",  {31'b0, ls_done},  32'h0);
        chk("rst_if_rdata", if_rdata,          32'h0);
        chk("rst_ls_rdata", ls_rdata,          32'h0);
        chk("rst_r_nw",     {31'b0, ram_r_nw}, 32'h1);
        chk("rst_ram_a",    {15'b0, ram_a},    32'h0);
        chk("rst_ram_dout", {24'b0, ram_dout}, 32'h0);
        chk("ram_en",       {31'b0, ram_en},   32'h1);

        // table-driven single accesses
        for (int i = 0; i < 11; i++) begin
            access(vecs[i].ls, vecs[i].we, vecs[i].sz, vecs[i].addr, vecs[i].wdata, rd, lat);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
            if (!vecs[i].we) chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
        end
        repeat (2) @(negedge clk);
        chk("rdata_hold", ls_rdata, 32'h00000033);

        // fetch address trace
        access(1'b0, 1'b0, 2'b10, 17'h10, 32'h0, rd, lat);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("fetch_a%0d", k), {15'b0, tr_a[k]}, 32'h10 + 32'(k));
            chk($sformatf("fetch_rnw%0d", k), {31'b0, tr_rnw[k]}, 32'h1);
        end

        // byte store trace
        access(1'b1, 1'b1, 2'b00, 17'h20, 32'hAABBCCDD, rd, lat);
        chk("st_a",    {15'b0, tr_a[0]},    32'h20);
        chk("st_rnw",  {31'b0, tr_rnw[0]},  32'h0);
        chk("st_dout", {24'b0, tr_dout[0]}, 32'hDD);
        chk("st_rnw_after", {31'b0, tr_rnw[1]}, 32'h1);

        // wrap-around word load
        access(1'b1, 1'b0, 2'b10, 17'h1FFFE, 32'h0, rd, lat);
        chk("wrap_a0", {15'b0, tr_a[0]}, 32'h1FFFE);
        chk("wrap_a1", {15'b0, tr_a[1]}, 32'h1FFFF);
        chk("wrap_a2", {15'b0, tr_a[2]}, 32'h00000);
        chk("wrap_a3", {15'b0, tr_a[3]}, 32'h00001);
        chk("wrap_rdata", rd, 32'hA4A3A2A1);

        // simultaneous requests right after reset: LS wins in both builds
        pulse_reset();
        @(negedge clk);
        ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b01; ls_addr = 17'h30;
        if_req = 1'b1; if_addr = 17'h10;
        ls_k = -1; if_k = -1; if_cap = '0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (ls_done && ls_k < 0) begin ls_k = k; ls_req = 1'b0; end
            if (if_done && if_k < 0) begin if_k = k; if_req = 1'b0; if_cap = if_rdata; end
            if (ls_k > 0 && if_k > 0) break;
        end
        ls_req = 1'b0; if_req = 1'b0;
        chk("tie_ls_lat", 32'(ls_k), 32'd4);
        chk("tie_if_lat", 32'(if_k), 32'd11);
        chk("tie_ls_rdata", ls_rdata, 32'h00006B5A);
        chk("tie_if_rdata", if_cap, 32'h44332211);

        // continuous dual requests
        pulse_reset();
        @(negedge clk);
        ls_we = 1'b0; ls_size = 2'b10; ls_addr = 17'h30; if_addr = 17'h10;
        ls_req = 1'b1; if_req = 1'b1;
        for (int r = 0; r < 4; r++) begin
            got = -1;
            for (int k = 1; k <= 20; k++) begin
                @(negedge clk);
                if (ls_done) begin got = 1; ls_req = 1'b0; break; end
                if (if_done) begin got = 0; if_req = 1'b0; break; end
            end
`ifdef MEM_ARB_RR_EN
            exp_got = (r % 2 == 0) ? 1 : 0;
`else
            exp_got = 1;
`endif
            chk($sformatf("alt_grant%0d", r), 32'(got), 32'(exp_got));
            if (r < 3) begin
                @(negedge clk);
                ls_req = 1'b1; if_req = 1'b1;
            end
        end
        ls_req = 1'b0; if_req = 1'b0;
        repeat (8) @(negedge clk);

        // reset in the middle of a word store
        @(negedge clk);
        ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'b10; ls_addr = 17'h40; ls_wdata = 32'h44332211;
        @(negedge clk);                  // byte 0 on the bus
        @(negedge clk);                  // byte 1 on the bus
        @(negedge clk);                  // cycle after byte 1 is written
        rst = 1'b1; ls_req = 1'b0;
        @(negedge clk);
        chk("abort_rnw", {31'b0, ram_r_nw}, 32'h1);
        chk("abort_state", 32'(dut.state_q), 32'(IDLE));
        rst = 1'b0;
        got = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ls_done) got = 1;
        end
        chk("abort_no_done", 32'(got), 32'd0);
        chk("abort_m40", {24'b0, mem[17'h40]}, 32'h11);
        chk("abort_m41", {24'b0, mem[17'h41]}, 32'h22);
        chk("abort_m42", {24'b0, mem[17'h42]}, 32'hEE);
        chk("abort_m43", {24'b0, mem[17'h43]}, 32'hEE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
